// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 frame layout, scan-code constants and sizing helper
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;
  localparam int START_IDX      = 0;
  localparam int PAR_IDX        = 9;
  localparam int STOP_IDX       = 10;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  // Bits needed to index 'value' entries; constant-evaluable for parameters.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock fall-through FIFO with extra-MSB full/empty pointers
module sync_fifo
  import ps2_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the slot the same cycle, so a full FIFO still takes a push then.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign head = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 device-to-host receiver feeding a scan-code FIFO
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       host_valid_n,
  output logic [7:0] data,
  output logic       device_ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int WD_W = clog2(TIMEOUT_CYCLES);

  logic [2:0]                clk_sync;
  logic [1:0]                dat_sync;
  logic                      fall;
  logic [3:0]                bit_cnt;
  logic [PS2_FRAME_BITS-1:0] shreg;
  logic                      frame_done;
  logic                      frame_good;
  logic                      push_req;
  logic [7:0]                push_byte;
  logic [WD_W-1:0]           wd_cnt;
  logic                      pop;
  logic [7:0]                fifo_head;
  logic                      fifo_empty;
  logic                      fifo_full;

  assign fall = clk_sync[2] & ~clk_sync[1];

  assign frame_good = ~shreg[START_IDX] & shreg[STOP_IDX] & (^shreg[PAR_IDX:START_IDX+1]);

  assign device_ready = ~fifo_empty;
  assign pop          = device_ready & ~host_valid_n;
  assign data         = device_ready ? fifo_head : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync   <= 3'b111;
      dat_sync   <= 2'b11;
      bit_cnt    <= '0;
      shreg      <= '0;
      frame_done <= 1'b0;
      push_req   <= 1'b0;
      push_byte  <= '0;
      wd_cnt     <= '0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[1:0], ps2_clk};
      dat_sync   <= {dat_sync[0], ps2_data};
      frame_done <= 1'b0;
      frame_err  <= 1'b0;

      if (fall) begin
        shreg  <= {dat_sync[1], shreg[PS2_FRAME_BITS-1:1]};
        wd_cnt <= '0;
        if (bit_cnt == 4'(STOP_IDX)) begin
          bit_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        // Device stopped clocking mid-frame: drop the partial frame.
        if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt   <= '0;
          wd_cnt    <= '0;
          frame_err <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt + WD_W'(1);
        end
      end else begin
        wd_cnt <= '0;
      end

      push_req  <= frame_done & frame_good;
      push_byte <= shreg[PAR_IDX-1:START_IDX+1];
      if (frame_done & ~frame_good) frame_err <= 1'b1;

      if (push_req & fifo_full & ~pop) overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (push_byte),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - directed self-checking bench for ps2_rx_fifo
module tb_ps2_rx_fifo;

  localparam int TMO  = 400;
  localparam int HALF = 20;

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       host_valid_n;
  logic [7:0] data;
  logic       device_ready;
  logic       overflow;
  logic       frame_err;

  int checks;
  int errors;
  int err_pulses;

  ps2_rx_fifo #(
    .FIFO_DEPTH     (8),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .host_valid_n (host_valid_n),
    .data         (data),
    .device_ready (device_ready),
    .overflow     (overflow),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) err_pulses++;

  function automatic logic [10:0] make_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      wait_clks(HALF);
      ps2_clk = 1'b0;
      wait_clks(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(make_frame(b), 11);
    ps2_data = 1'b1;
    wait_clks(10);
  endtask

  task automatic pop_one();
    @(negedge clk) host_valid_n = 1'b0;
    @(negedge clk) host_valid_n = 1'b1;
  endtask

  task automatic pulse_rst();
    @(negedge clk) rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clks(4);
    checks++; if (device_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", device_ready); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
    rst = 1'b0;
    wait_clks(2);
  endtask

  task automatic test_single();
    int cnt;
    int e0;
    e0 = err_pulses;
    send_bits(make_frame(8'h1C), 10);
    ps2_data = 1'b1;
    wait_clks(HALF);
    ps2_clk = 1'b0;
    cnt = 0;
    while (device_ready !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    checks++; if (cnt != 5) begin errors++; $display("FAIL single_latency got %0d exp 5", cnt); end
    wait_clks(HALF);
    ps2_clk = 1'b1;
    wait_clks(10);
    checks++; if (device_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", device_ready); end
    checks++; if (data !== 8'h1C) begin errors++; $display("FAIL single_data got %h exp 1c", data); end
    checks++; if (err_pulses != e0) begin errors++; $display("FAIL single_no_err got %0d exp %0d", err_pulses, e0); end
    pop_one();
    wait_clks(1);
    checks++; if (device_ready !== 1'b0) begin errors++; $display("FAIL single_empty got %b exp 0", device_ready); end
  endtask

  task automatic test_back_to_back();
    send_byte(8'hF0);
    send_byte(8'h1C);
    checks++; if (data !== 8'hF0) begin errors++; $display("FAIL b2b_first got %h exp f0", data); end
    pop_one();
    checks++; if (data !== 8'h1C) begin errors++; $display("FAIL b2b_second got %h exp 1c", data); end
    checks++; if (device_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", device_ready); end
    pop_one();
    checks++; if (device_ready !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", device_ready); end
  endtask

  task automatic test_parity_err();
    int e0;
    logic [10:0] f;
    e0 = err_pulses;
    f = make_frame(8'h1C);
    f[9] = ~f[9];
    send_bits(f, 11);
    wait_clks(10);
    checks++; if (err_pulses != e0 + 1) begin errors++; $display("FAIL parity_err_pulses got %0d exp %0d", err_pulses - e0, 1); end
    checks++; if (device_ready !== 1'b0) begin errors++; $display("FAIL parity_empty got %b exp 0", device_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL parity_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_before got %b exp 0", overflow); end
    send_byte(8'h18);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_after got %b exp 1", overflow); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (data !== 8'h10 + 8'(i)) begin errors++; $display("FAIL ovf_data[%0d] got %h exp %h", i, data, 8'h10 + 8'(i)); end
      pop_one();
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky[%0d] got %b exp 1", i, overflow); end
    end
    checks++; if (device_ready !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b exp 0", device_ready); end
    pulse_rst();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared got %b exp 0", overflow); end
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_pulses;
    send_bits(make_frame(8'h32), 5);
    ps2_data = 1'b1;
    wait_clks(TMO + 20);
    checks++; if (err_pulses != e0 + 1) begin errors++; $display("FAIL timeout_pulse got %0d exp 1", err_pulses - e0); end
    send_byte(8'h32);
    checks++; if (data !== 8'h32) begin errors++; $display("FAIL timeout_data got %h exp 32", data); end
    checks++; if (err_pulses != e0 + 1) begin errors++; $display("FAIL timeout_no_extra got %0d exp 1", err_pulses - e0); end
    pop_one();
  endtask

  task automatic test_reset_mid();
    int e0;
    e0 = err_pulses;
    send_bits(make_frame(8'h45), 6);
    @(negedge clk) rst = 1'b1;
    wait_clks(2);
    checks++; if ({device_ready, overflow, frame_err, data} !== 11'd0) begin errors++; $display("FAIL rstmid_outputs got %b exp 0", {device_ready, overflow, frame_err, data}); end
    rst = 1'b0;
    wait_clks(TMO + 20);
    checks++; if (err_pulses != e0) begin errors++; $display("FAIL rstmid_no_err got %0d exp 0", err_pulses - e0); end
    send_byte(8'h45);
    checks++; if (data !== 8'h45) begin errors++; $display("FAIL rstmid_data got %h exp 45", data); end
    checks++; if (device_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", device_ready); end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    err_pulses   = 0;
    rst          = 1'b1;
    ps2_clk      = 1'b1;
    ps2_data     = 1'b1;
    host_valid_n = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_parity_err();
    test_overflow();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
